ysyx_23060229_mem_arbiter: RTL and testbench

YSYX_23060229_MEM_ARBITER -- requirements
Module: ysyx_23060229_mem_arbiter

---
 rtl/ysyx_23060229_pkg.sv | 22 ++
 rtl/ysyx_23060229_rr_arbiter.sv | 26 ++
 rtl/ysyx_23060229_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ysyx_23060229_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060229_pkg.sv
// Shared definitions for the memory arbiter: transfer size codes,
// arbiter FSM states and transaction owner identifiers.
package ysyx_23060229_pkg;

  // Size encoding used on every wen/ren port.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060229_rr_arbiter.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// requester that was not granted last wins. Grant is one-hot:
// bit 0 = instruction fetch, bit 1 = load/store.
module ysyx_23060229_rr_arbiter
  import ysyx_23060229_pkg::*;
(
  input  logic       if_valid,
  input  logic       ls_valid,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  // Pick the winner from the current valids and the previous winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    if (if_valid && ls_valid) begin
      grant = (last_grant == OWN_LS) ? 2'b01 : 2'b10;
    end else if (if_valid) begin
      grant = 2'b01;
    end else if (ls_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_23060229_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction in flight at a time: IDLE accepts and registers a request,
// REQ presents it to memory until accepted, RESP waits for the memory
// response and forwards it to the owner. LS requests with no read and no
// write complete locally without touching memory.
module ysyx_23060229_mem_arbiter
  import ysyx_23060229_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_resp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [1:0]            ls_wen,
  input  logic [1:0]            ls_ren,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_resp_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_wen,
  output logic [1:0]            mem_ren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  busy
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            wen_q, wen_d;
  logic [1:0]            ren_q, ren_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [1:0] grant;
  logic       can_accept;
  logic       no_access;
  logic       resp_fire;

  ysyx_23060229_rr_arbiter u_rr_arbiter (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Readies are offered only in IDLE and are forced low while reset is held.
  assign can_accept   = (state_q == ST_IDLE) && rst;
  assign if_req_ready = can_accept && grant[0];
  assign ls_req_ready = can_accept && grant[1];

  // A transaction with neither read nor write never reaches memory; it
  // answers on its first RESP cycle instead of waiting for mem_resp_valid.
  assign no_access = (wen_q == SZ_NONE) && (ren_q == SZ_NONE);
  assign resp_fire = (state_q == ST_RESP) && (no_access || mem_resp_valid);

  // Next-state and capture logic for the accepted transaction.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    ren_d        = ren_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req_ready) begin
          owner_d      = OWN_IF;
          last_grant_d = OWN_IF;
          addr_d       = if_addr;
          wen_d        = SZ_NONE;
          ren_d        = SZ_WORD;
          wdata_d      = '0;
          state_d      = ST_REQ;
        end else if (ls_req_ready) begin
          owner_d      = OWN_LS;
          last_grant_d = OWN_LS;
          addr_d       = ls_addr;
          wen_d        = ls_wen;
          // A request carrying both a write and a read is issued as a write.
          ren_d        = (ls_wen != SZ_NONE) ? SZ_NONE : ls_ren;
          wdata_d      = ls_wdata;
          state_d      = ((ls_wen == SZ_NONE) && (ls_ren == SZ_NONE)) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_LS;
      addr_q       <= '0;
      wen_q        <= SZ_NONE;
      ren_q        <= SZ_NONE;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory request side comes straight from the registered fields.
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_ren       = ren_q;
  assign mem_wdata     = wdata_q;

  // Response is steered to the owner only; the other side stays at zero.
  assign if_resp_valid = resp_fire && (owner_q == OWN_IF);
  assign ls_resp_valid = resp_fire && (owner_q == OWN_LS);
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign ls_rdata      = (ls_resp_valid && !no_access) ? mem_rdata : '0;

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_23060229_mem_arbiter.sv
// Self-checking bench for ysyx_23060229_mem_arbiter: table-driven single
// transactions, hand-written multi-cycle sequences and a randomized run
// compared against a transaction-level reference model.
module tb_ysyx_23060229_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_resp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_wen, ls_ren;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_wen, mem_ren;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060229_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_rdata       (if_rdata),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_addr        (ls_addr),
    .ls_wen         (ls_wen),
    .ls_ren         (ls_ren),
    .ls_wdata       (ls_wdata),
    .ls_resp_valid  (ls_resp_valid),
    .ls_rdata       (ls_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_ren        (mem_ren),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Watchdog: every sequence is cycle-bounded, this only guards against a stuck simulator.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid   = 1'b0;
    if_addr        = '0;
    ls_req_valid   = 1'b0;
    ls_addr        = '0;
    ls_wen         = 2'b00;
    ls_ren         = 2'b00;
    ls_wdata       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  // Drives the remainder of a memory transaction from the REQ cycle onward.
  task automatic finish_mem_txn(input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    tick();
    mem_resp_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        is_ls;
    logic [31:0] addr;
    logic [1:0]  wen;
    logic [1:0]  ren;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic        exp_mem;
    logic [1:0]  exp_wen;
    logic [1:0]  exp_ren;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_ls) begin
      ls_req_valid = 1'b1;
      ls_addr      = v.addr;
      ls_wen       = v.wen;
      ls_ren       = v.ren;
      ls_wdata     = v.wdata;
    end else begin
      if_req_valid = 1'b1;
      if_addr      = v.addr;
    end
    #1;
    check({tag, "_if_ready"}, 64'(if_req_ready), 64'(!v.is_ls));
    check({tag, "_ls_ready"}, 64'(ls_req_ready), 64'(v.is_ls));
    tick();
    // Scramble the request inputs so the registered copy is what gets checked.
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    if_addr      = ~v.addr;
    ls_addr      = ~v.addr;
    ls_wdata     = ~v.wdata;
    ls_wen       = ~v.wen;
    ls_ren       = ~v.ren;
    #1;
    check({tag, "_busy"}, 64'(busy), 64'(1));
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'(v.exp_mem));
    if (v.exp_mem) begin
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'(v.addr));
      check({tag, "_mem_wen"}, 64'(mem_wen), 64'(v.exp_wen));
      check({tag, "_mem_ren"}, 64'(mem_ren), 64'(v.exp_ren));
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(v.exp_wdata));
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = v.mem_rdata;
      #1;
      check({tag, "_mem_req_valid_resp"}, 64'(mem_req_valid), 64'(0));
    end else begin
      mem_rdata = v.mem_rdata;
      #1;
    end
    check({tag, "_if_resp_valid"}, 64'(if_resp_valid), 64'(!v.is_ls));
    check({tag, "_ls_resp_valid"}, 64'(ls_resp_valid), 64'(v.is_ls));
    check({tag, "_if_rdata"}, 64'(if_rdata), v.is_ls ? 64'(0) : 64'(v.exp_rdata));
    check({tag, "_ls_rdata"}, 64'(ls_rdata), v.is_ls ? 64'(v.exp_rdata) : 64'(0));
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_idle_if_resp"}, 64'(if_resp_valid), 64'(0));
    check({tag, "_idle_ls_resp"}, 64'(ls_resp_valid), 64'(0));
    idle_inputs();
  endtask

  // Transaction-level reference model for the randomized run.
  typedef struct {
    logic        own_ls;
    logic [31:0] addr;
    logic [1:0]  wen;
    logic [1:0]  ren;
    logic [31:0] wdata;
  } txn_t;

  task automatic random_run(input int cycles);
    bit   m_busy    = 1'b0;
    bit   m_sent    = 1'b0;
    bit   m_last_ls = 1'b1;
    txn_t m_txn     = '{1'b0, 32'h0, 2'b00, 2'b00, 32'h0};
    bit   g_if, g_ls, no_mem, e_mreq, e_resp;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if_req_valid   = 1'($urandom_range(0, 1));
      if_addr        = $urandom;
      ls_req_valid   = 1'($urandom_range(0, 1));
      ls_addr        = $urandom;
      ls_wen         = 2'($urandom_range(0, 3));
      ls_ren         = 2'($urandom_range(0, 3));
      ls_wdata       = $urandom;
      mem_req_ready  = ($urandom_range(0, 2) != 0);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_rdata      = $urandom;
      #1;
      g_if = 1'b0;
      g_ls = 1'b0;
      if (!m_busy) begin
        if (if_req_valid && ls_req_valid) begin
          g_if = m_last_ls;
          g_ls = !m_last_ls;
        end else begin
          g_if = if_req_valid;
          g_ls = ls_req_valid;
        end
      end
      no_mem = m_txn.own_ls && (m_txn.wen == 2'b00) && (m_txn.ren == 2'b00);
      e_mreq = m_busy && !no_mem && !m_sent;
      e_resp = m_busy && (no_mem || (m_sent && mem_resp_valid));
      check("rnd_if_ready", 64'(if_req_ready), 64'(g_if));
      check("rnd_ls_ready", 64'(ls_req_ready), 64'(g_ls));
      check("rnd_busy", 64'(busy), 64'(m_busy));
      check("rnd_mem_req_valid", 64'(mem_req_valid), 64'(e_mreq));
      check("rnd_if_resp", 64'(if_resp_valid), 64'(e_resp && !m_txn.own_ls));
      check("rnd_ls_resp", 64'(ls_resp_valid), 64'(e_resp && m_txn.own_ls));
      if (e_mreq) begin
        check("rnd_mem_addr", 64'(mem_addr), 64'(m_txn.addr));
        check("rnd_mem_wen", 64'(mem_wen), 64'(m_txn.wen));
        check("rnd_mem_ren", 64'(mem_ren), 64'(m_txn.ren));
        check("rnd_mem_wdata", 64'(mem_wdata), 64'(m_txn.wdata));
      end
      if (e_resp && !m_txn.own_ls) check("rnd_if_rdata", 64'(if_rdata), 64'(mem_rdata));
      if (e_resp && m_txn.own_ls)
        check("rnd_ls_rdata", 64'(ls_rdata), no_mem ? 64'(0) : 64'(mem_rdata));
      if (m_busy && m_txn.own_ls) check("rnd_if_rdata_nonowner", 64'(if_rdata), 64'(0));
      if (m_busy && !m_txn.own_ls) check("rnd_ls_rdata_nonowner", 64'(ls_rdata), 64'(0));
      // Advance the model across the clock edge.
      if (e_resp) begin
        m_busy = 1'b0;
      end else if (e_mreq && mem_req_ready) begin
        m_sent = 1'b1;
      end else if (g_if) begin
        m_txn     = '{1'b0, if_addr, 2'b00, 2'b11, 32'h0};
        m_busy    = 1'b1;
        m_sent    = 1'b0;
        m_last_ls = 1'b0;
      end else if (g_ls) begin
        m_txn     = '{1'b1, ls_addr, ls_wen, (ls_wen != 2'b00) ? 2'b00 : ls_ren, ls_wdata};
        m_busy    = 1'b1;
        m_sent    = 1'b0;
        m_last_ls = 1'b1;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0000, 2'b00, 2'b00, 32'h0,         32'h0000_0413, 1'b1, 2'b00, 2'b11, 32'h0,         32'h0000_0413};
    vecs[1] = '{1'b1, 32'h8000_0010, 2'b00, 2'b11, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 2'b00, 2'b11, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h8000_0022, 2'b10, 2'b00, 32'h0000_BEEF, 32'h5555_5555, 1'b1, 2'b10, 2'b00, 32'h0000_BEEF, 32'h5555_5555};
    vecs[3] = '{1'b1, 32'h8000_0030, 2'b11, 2'b01, 32'hCAFE_F00D, 32'h0,         1'b1, 2'b11, 2'b00, 32'hCAFE_F00D, 32'h0};
    vecs[4] = '{1'b1, 32'h8000_0040, 2'b00, 2'b00, 32'h1111_2222, 32'hFFFF_FFFF, 1'b0, 2'b00, 2'b00, 32'h0,         32'h0};
    vecs[5] = '{1'b1, 32'h8000_0041, 2'b00, 2'b01, 32'h0,         32'h0000_00A5, 1'b1, 2'b00, 2'b01, 32'h0,         32'h0000_00A5};
    vecs[6] = '{1'b0, 32'h8000_0004, 2'b00, 2'b00, 32'h0,         32'h0010_0093, 1'b1, 2'b00, 2'b11, 32'h0,         32'h0010_0093};

    // Reset state: outputs low, readies low even with both requesters valid.
    idle_inputs();
    rst          = 1'b0;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    #2;
    check("rst_if_ready", 64'(if_req_ready), 64'(0));
    check("rst_ls_ready", 64'(ls_req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wen_ren", 64'({mem_wen, mem_ren}), 64'(0));
    check("rst_resp", 64'({if_resp_valid, ls_resp_valid}), 64'(0));
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    #1;

    // Single-transaction vectors.
    for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);

    // Simultaneous requests after reset: IF, LS, IF; each accepted the cycle after the previous response.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if_req_valid = 1'b1;
      if_addr      = 32'h8000_0100;
      ls_req_valid = 1'b1;
      ls_addr      = 32'h8000_0200;
      ls_ren       = 2'b11;
      #1;
      check($sformatf("tie%0d_if_ready", i), 64'(if_req_ready), 64'(i != 1));
      check($sformatf("tie%0d_ls_ready", i), 64'(ls_req_ready), 64'(i == 1));
      tick();
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      finish_mem_txn(32'h0);
    end
    idle_inputs();

    // Store held off by memory for 3 cycles; spurious response during REQ ignored.
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_1003;
    ls_wen       = 2'b01;
    ls_wdata     = 32'hAABB_CCDD;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      mem_req_ready  = (i == 3);
      mem_resp_valid = (i == 1);
      #1;
      check($sformatf("stall%0d_mem_req_valid", i), 64'(mem_req_valid), 64'(1));
      check($sformatf("stall%0d_mem_addr", i), 64'(mem_addr), 64'h8000_1003);
      check($sformatf("stall%0d_mem_wen", i), 64'(mem_wen), 64'(2'b01));
      check($sformatf("stall%0d_mem_ren", i), 64'(mem_ren), 64'(2'b00));
      check($sformatf("stall%0d_mem_wdata", i), 64'(mem_wdata), 64'hAABB_CCDD);
      check($sformatf("stall%0d_ls_resp", i), 64'(ls_resp_valid), 64'(0));
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    check("stall_mem_req_valid_after", 64'(mem_req_valid), 64'(0));
    check("stall_ls_resp_ack", 64'(ls_resp_valid), 64'(1));
    check("stall_if_resp", 64'(if_resp_valid), 64'(0));
    tick();
    idle_inputs();

    // Spurious memory response while idle.
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_ABCD;
    #1;
    check("spur_if_resp", 64'(if_resp_valid), 64'(0));
    check("spur_ls_resp", 64'(ls_resp_valid), 64'(0));
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check("spur_busy", 64'(busy), 64'(0));

    // Reset asserted while in RESP; late memory response must be dropped.
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_0008;
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("midrst_busy_before", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    check("midrst_busy_during", 64'(busy), 64'(0));
    check("midrst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    tick();
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hDEAD_0001;
    #1;
    check("midrst_if_resp", 64'(if_resp_valid), 64'(0));
    check("midrst_ls_resp", 64'(ls_resp_valid), 64'(0));
    check("midrst_busy_after", 64'(busy), 64'(0));
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check("midrst_still_idle", 64'(busy), 64'(0));

    // Randomized traffic against the reference model.
    do_reset();
    random_run(1500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
